adder_rr_arbiter: RTL and testbench

Shares a single `ripple_carry_adder` instance among `NUM_REQ` requesters using round-robin arbitration. Each request carries two operands and uses a valid/ready handshake. The sum, carry-out and the winning requester's ID are registered into a one-entry output stage with its own valid/ready handshake. The block sits between multiple issuing units and the shared adder datapath, so that one adder serves all of them at up to one addition per cycle.

---
 rtl/adder_rr_arbiter.sv | 131 +++++++++++++
 tb/tb_adder_rr_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_rr_arbiter.sv
// rtl/adder_rr_arbiter.sv - round-robin arbiter sharing one ripple-carry adder among requesters
// Result is registered in a one-entry valid/ready output stage.

module ripple_carry_adder #(
  parameter int LENGTH = 16
) (
  input  logic [LENGTH-1:0] a_i,
  input  logic [LENGTH-1:0] b_i,
  input  logic              carry_i,
  output logic [LENGTH-1:0] sum_o,
  output logic              carry_o
);

  logic [LENGTH:0] c;

  assign c[0] = carry_i;

  for (genvar i = 0; i < LENGTH; i++) begin : g_bit
    assign sum_o[i]  = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]    = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign carry_o = c[LENGTH];

endmodule

module adder_rr_arbiter #(
  parameter int LENGTH  = 16,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ-1:0][LENGTH-1:0]   req_a_i,
  input  logic [NUM_REQ-1:0][LENGTH-1:0]   req_b_i,
  output logic                             rsp_valid_o,
  input  logic                             rsp_ready_i,
  output logic [LENGTH-1:0]                rsp_sum_o,
  output logic                             rsp_carry_o,
  output logic [ID_W-1:0]                  rsp_id_o
);

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [LENGTH-1:0] rsp_sum_q, rsp_sum_d;
  logic              rsp_carry_q, rsp_carry_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;

  logic              any_valid;
  logic [ID_W-1:0]   grant_idx;
  logic              accept;
  logic [LENGTH-1:0] a_sel, b_sel, add_sum;
  logic              add_carry;

  // First valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin : grant_search
    int idx;
    logic [ID_W-1:0] cand;
    idx       = 0;
    cand      = '0;
    any_valid = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (!any_valid && req_valid_i[cand]) begin
        any_valid = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // rst_ni gates accept so no ready is offered while held in reset.
  assign accept      = any_valid & rst_ni & (~rsp_valid_q | rsp_ready_i);
  assign req_ready_o = accept ? (NUM_REQ'(1) << grant_idx) : '0;

  assign a_sel = req_a_i[grant_idx];
  assign b_sel = req_b_i[grant_idx];

  ripple_carry_adder #(
    .LENGTH (LENGTH)
  ) u_adder (
    .a_i     (a_sel),
    .b_i     (b_sel),
    .carry_i (1'b0),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_carry_d = rsp_carry_q;
    rsp_id_d    = rsp_id_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_sum_d   = add_sum;
      rsp_carry_d = add_carry;
      rsp_id_d    = grant_idx;
      ptr_d       = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end else if (rsp_valid_q && rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_sum_o   = rsp_sum_q;
  assign rsp_carry_o = rsp_carry_q;
  assign rsp_id_o    = rsp_id_q;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// tb/tb_adder_rr_arbiter.sv - directed self-checking bench for adder_rr_arbiter
module tb_adder_rr_arbiter;

  localparam int LENGTH  = 16;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                           clk = 1'b0;
  logic                           rst_ni;
  logic [NUM_REQ-1:0]             req_valid_i;
  logic [NUM_REQ-1:0]             req_ready_o;
  logic [NUM_REQ-1:0][LENGTH-1:0] req_a_i;
  logic [NUM_REQ-1:0][LENGTH-1:0] req_b_i;
  logic                           rsp_valid_o;
  logic                           rsp_ready_i;
  logic [LENGTH-1:0]              rsp_sum_o;
  logic                           rsp_carry_o;
  logic [ID_W-1:0]                rsp_id_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  adder_rr_arbiter #(
    .LENGTH  (LENGTH),
    .NUM_REQ (NUM_REQ)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_sum_o   (rsp_sum_o),
    .rsp_carry_o (rsp_carry_o),
    .rsp_id_o    (rsp_id_o)
  );

  typedef struct {
    logic [3:0]       valid;
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
    logic             rdy;
    logic [3:0]       exp_ready;
    logic             exp_valid;
    logic [15:0]      exp_sum;
    logic             exp_carry;
    logic [1:0]       exp_id;
  } vec_t;

  vec_t vecs[7];

  logic [3:0][15:0] opa, opb, zero_ops;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_rsp(input string nm, input logic v, input logic [15:0] s,
                         input logic c, input logic [1:0] id);
    chk({nm, " valid"}, 32'(rsp_valid_o), 32'(v));
    chk({nm, " sum"},   32'(rsp_sum_o),   32'(s));
    chk({nm, " carry"}, 32'(rsp_carry_o), 32'(c));
    chk({nm, " id"},    32'(rsp_id_o),    32'(id));
  endtask

  task automatic do_reset();
    rst_ni      = 1'b0;
    req_valid_i = 4'hF;
    rsp_ready_i = 1'b1;
    #1;
    chk("ready in reset", 32'(req_ready_o), 32'h0);
    step();
    step();
    chk_rsp("reset", 1'b0, 16'h0, 1'b0, 2'd0);
    req_valid_i = 4'h0;
    rst_ni      = 1'b1;
  endtask

  initial begin
    opa      = {16'h8000, 16'h0003, 16'h0010, 16'h0001};
    opb      = {16'h8001, 16'h0004, 16'h0020, 16'h0002};
    zero_ops = '0;

    vecs[0] = '{valid:4'b0100, a:{16'h0, 16'h1234, 16'h0, 16'h0}, b:{16'h0, 16'h0FFF, 16'h0, 16'h0},
                rdy:1'b1, exp_ready:4'b0100, exp_valid:1'b1, exp_sum:16'h2233, exp_carry:1'b0, exp_id:2'd2};
    vecs[1] = '{valid:4'b0001, a:{16'h0, 16'h0, 16'h0, 16'hFFFF}, b:{16'h0, 16'h0, 16'h0, 16'h0001},
                rdy:1'b1, exp_ready:4'b0001, exp_valid:1'b1, exp_sum:16'h0000, exp_carry:1'b1, exp_id:2'd0};
    vecs[2] = '{valid:4'b0000, a:zero_ops, b:zero_ops,
                rdy:1'b1, exp_ready:4'b0000, exp_valid:1'b0, exp_sum:16'h0000, exp_carry:1'b1, exp_id:2'd0};
    vecs[3] = '{valid:4'b1111, a:opa, b:opb,
                rdy:1'b1, exp_ready:4'b0010, exp_valid:1'b1, exp_sum:16'h0030, exp_carry:1'b0, exp_id:2'd1};
    vecs[4] = '{valid:4'b1111, a:opa, b:opb,
                rdy:1'b1, exp_ready:4'b0100, exp_valid:1'b1, exp_sum:16'h0007, exp_carry:1'b0, exp_id:2'd2};
    vecs[5] = '{valid:4'b1111, a:opa, b:opb,
                rdy:1'b1, exp_ready:4'b1000, exp_valid:1'b1, exp_sum:16'h0001, exp_carry:1'b1, exp_id:2'd3};
    vecs[6] = '{valid:4'b1111, a:opa, b:opb,
                rdy:1'b1, exp_ready:4'b0001, exp_valid:1'b1, exp_sum:16'h0003, exp_carry:1'b0, exp_id:2'd0};

    req_a_i = '0;
    req_b_i = '0;
    do_reset();

    for (int i = 0; i < 7; i++) begin
      req_valid_i = vecs[i].valid;
      req_a_i     = vecs[i].a;
      req_b_i     = vecs[i].b;
      rsp_ready_i = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d ready", i), 32'(req_ready_o), 32'(vecs[i].exp_ready));
      step();
      chk_rsp($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_sum,
              vecs[i].exp_carry, vecs[i].exp_id);
    end

    // Round-robin from reset with every requester asserting
    do_reset();
    req_a_i     = opa;
    req_b_i     = opb;
    req_valid_i = 4'hF;
    rsp_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("rr%0d ready", k), 32'(req_ready_o), 32'(4'b0001 << (k % 4)));
      step();
      chk($sformatf("rr%0d id", k), 32'(rsp_id_o), 32'(k % 4));
      chk($sformatf("rr%0d valid", k), 32'(rsp_valid_o), 32'h1);
    end

    // Backpressure: result for id1 held, ptr=2
    rsp_ready_i = 1'b0;
    #1;
    chk("bp ready", 32'(req_ready_o), 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("bp%0d ready", k), 32'(req_ready_o), 32'h0);
      chk_rsp($sformatf("bp%0d", k), 1'b1, 16'h0030, 1'b0, 2'd1);
    end
    rsp_ready_i = 1'b1;
    #1;
    chk("bp release ready", 32'(req_ready_o), 32'(4'b0100));
    step();
    chk_rsp("bp drain+accept", 1'b1, 16'h0007, 1'b0, 2'd2);

    // Pointer hold across idle cycles, then wrap past the top
    do_reset();
    req_a_i     = opa;
    req_b_i     = opb;
    req_valid_i = 4'b0010;
    rsp_ready_i = 1'b1;
    #1;
    chk("hold grant1", 32'(req_ready_o), 32'(4'b0010));
    step();
    chk_rsp("hold rsp1", 1'b1, 16'h0030, 1'b0, 2'd1);
    req_valid_i = 4'b0000;
    repeat (5) step();
    chk("hold drained", 32'(rsp_valid_o), 32'h0);
    req_valid_i = 4'b0011;
    #1;
    chk("wrap grant", 32'(req_ready_o), 32'(4'b0001));
    req_valid_i = 4'b0101;
    #1;
    chk("held ptr grant", 32'(req_ready_o), 32'(4'b0100));
    step();
    chk_rsp("held ptr rsp", 1'b1, 16'h0007, 1'b0, 2'd2);

    // Reset while stalled
    req_valid_i = 4'b0001;
    rsp_ready_i = 1'b0;
    step();
    chk("stall valid", 32'(rsp_valid_o), 32'h1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_rsp("mid reset", 1'b0, 16'h0, 1'b0, 2'd0);
    chk("mid reset ready", 32'(req_ready_o), 32'h0);
    #1;
    rst_ni      = 1'b1;
    req_valid_i = 4'hF;
    rsp_ready_i = 1'b1;
    #1;
    chk("post reset grant", 32'(req_ready_o), 32'(4'b0001));
    step();
    chk_rsp("post reset rsp", 1'b1, 16'h0003, 1'b0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
